// File: rtl/axi_port_arbiter.sv
// axi_port_arbiter
// Funnels N requester ports onto one AXI3 master. Reads and writes have separate
// arbiters, and each direction allows one transaction in flight at a time. The
// granted port index is driven on ARID/AWID. Read data and response fields are
// broadcast to every port; only the granted port's valid bit is ever raised.
//
// Handshake rule for every channel: a beat transfers on a rising edge where
// valid and ready are both 1. A source holds valid and payload stable until
// that happens. The arbiter passes each port's ready/valid straight through
// once that port holds the grant. Non-granted ports see 0 and keep requesting.
//
// Build option: define ARB_FIXED_PRIO_EN to always grant the lowest-index
// requester. The round-robin pointers are then removed. If it is left
// undefined, the scan starts at the port after the last one that completed.
module axi_port_arbiter #(
  parameter int N_PORTS = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  // requester read address / data
  input  logic [N_PORTS-1:0]         s_arvalid,
  output logic [N_PORTS-1:0]         s_arready,
  input  logic [N_PORTS*ADDR_W-1:0]  s_araddr,
  input  logic [N_PORTS*8-1:0]       s_arlen,
  input  logic [N_PORTS*3-1:0]       s_arsize,
  output logic [N_PORTS-1:0]         s_rvalid,
  input  logic [N_PORTS-1:0]         s_rready,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rlast,
  // requester write address / data / response
  input  logic [N_PORTS-1:0]         s_awvalid,
  output logic [N_PORTS-1:0]         s_awready,
  input  logic [N_PORTS*ADDR_W-1:0]  s_awaddr,
  input  logic [N_PORTS*8-1:0]       s_awlen,
  input  logic [N_PORTS*3-1:0]       s_awsize,
  input  logic [N_PORTS-1:0]         s_wvalid,
  output logic [N_PORTS-1:0]         s_wready,
  input  logic [N_PORTS*DATA_W-1:0]  s_wdata,
  input  logic [N_PORTS*DATA_W/8-1:0] s_wstrb,
  input  logic [N_PORTS-1:0]         s_wlast,
  output logic [N_PORTS-1:0]         s_bvalid,
  input  logic [N_PORTS-1:0]         s_bready,
  output logic [1:0]                 s_bresp,
  // external AXI3 master
  output logic [ID_W-1:0]            m_arid,
  output logic [ADDR_W-1:0]          m_araddr,
  output logic [7:0]                 m_arlen,
  output logic [2:0]                 m_arsize,
  output logic [1:0]                 m_arburst,
  output logic [1:0]                 m_arlock,
  output logic [3:0]                 m_arcache,
  output logic [2:0]                 m_arprot,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  input  logic [ID_W-1:0]            m_rid,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rlast,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  output logic [ID_W-1:0]            m_awid,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic [7:0]                 m_awlen,
  output logic [2:0]                 m_awsize,
  output logic [1:0]                 m_awburst,
  output logic [1:0]                 m_awlock,
  output logic [3:0]                 m_awcache,
  output logic [2:0]                 m_awprot,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [ID_W-1:0]            m_wid,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  output logic                       m_wlast,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [ID_W-1:0]            m_bid,
  input  logic [1:0]                 m_bresp,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  // debug visibility
  output logic [1:0]                 o_dbg_rd_state,
  output logic [1:0]                 o_dbg_wr_state,
  output logic [2:0]                 o_dbg_rd_ptr,
  output logic [2:0]                 o_dbg_wr_ptr,
  output logic                       o_dbg_rsp_id_err
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ADDR = 2'd1, WR_DATA = 2'd2, WR_RESP = 2'd3} wr_state_t;

  // First asserted request at or above ptr, wrapping modulo N_PORTS.
  function automatic logic [PW-1:0] f_pick(input logic [N_PORTS-1:0] req,
                                           input logic [PW-1:0] ptr);
    logic [PW-1:0] win;
    logic          found;
    int            idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(ptr) + i) % N_PORTS;
      if (!found && req[idx]) begin
        win   = PW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Next port after g, wrapping at N_PORTS-1.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] g);
    return (g == PW'(N_PORTS - 1)) ? '0 : g + 1'b1;
  endfunction

  rd_state_t         r_rd_state, w_rd_next;
  wr_state_t         r_wr_state, w_wr_next;
  logic [PW-1:0]     r_rd_gnt, r_wr_gnt;
  logic [PW-1:0]     w_rd_ptr, w_wr_ptr;
  logic [PW-1:0]     w_rd_win, w_wr_win;
  logic              w_rd_done, w_wr_done;
  logic [ADDR_W-1:0] r_araddr, r_awaddr;
  logic [7:0]        r_arlen, r_awlen;
  logic [2:0]        r_arsize, r_awsize;

  assign w_rd_win  = f_pick(s_arvalid, w_rd_ptr);
  assign w_wr_win  = f_pick(s_awvalid, w_wr_ptr);
  assign w_rd_done = (r_rd_state == RD_DATA) && m_rvalid && m_rready && m_rlast;
  assign w_wr_done = (r_wr_state == WR_RESP) && m_bvalid && m_bready;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: the scan always starts at port 0.
  assign w_rd_ptr = '0;
  assign w_wr_ptr = '0;
`else
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  assign w_rd_ptr = r_rd_ptr;
  assign w_wr_ptr = r_wr_ptr;

  // Round-robin pointers move past the port whose transaction just completed.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_rd_done) r_rd_ptr <= f_next(r_rd_gnt);
      if (w_wr_done) r_wr_ptr <= f_next(r_wr_gnt);
    end
  end
`endif

  // ---------------------------------------------------------------- read path

  // Read state, grant and captured AR fields.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rd_state <= RD_IDLE;
      r_rd_gnt   <= '0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arsize   <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if ((r_rd_state == RD_IDLE) && (|s_arvalid)) begin
        r_rd_gnt <= w_rd_win;
        r_araddr <= s_araddr[w_rd_win*ADDR_W +: ADDR_W];
        r_arlen  <= s_arlen[w_rd_win*8 +: 8];
        r_arsize <= s_arsize[w_rd_win*3 +: 3];
      end
    end
  end

  // Read next state and per-port steering.
  always_comb begin
    w_rd_next = r_rd_state;
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (|s_arvalid) begin
          s_arready[w_rd_win] = 1'b1;
          w_rd_next           = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (m_arready) w_rd_next = RD_DATA;
      end
      RD_DATA: begin
        s_rvalid[r_rd_gnt] = m_rvalid;
        m_rready           = s_rready[r_rd_gnt];
        if (m_rvalid && s_rready[r_rd_gnt] && m_rlast) w_rd_next = RD_IDLE;
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  assign m_arvalid = (r_rd_state == RD_ADDR);
  assign m_arid    = ID_W'(r_rd_gnt);
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign m_arsize  = r_arsize;
  assign m_arburst = 2'b01;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;

  // --------------------------------------------------------------- write path

  // Write state, grant and captured AW fields.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_state <= WR_IDLE;
      r_wr_gnt   <= '0;
      r_awaddr   <= '0;
      r_awlen    <= '0;
      r_awsize   <= '0;
    end else begin
      r_wr_state <= w_wr_next;
      if ((r_wr_state == WR_IDLE) && (|s_awvalid)) begin
        r_wr_gnt <= w_wr_win;
        r_awaddr <= s_awaddr[w_wr_win*ADDR_W +: ADDR_W];
        r_awlen  <= s_awlen[w_wr_win*8 +: 8];
        r_awsize <= s_awsize[w_wr_win*3 +: 3];
      end
    end
  end

  // Write next state, W-channel mux and B steering.
  always_comb begin
    w_wr_next = r_wr_state;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if (|s_awvalid) begin
          s_awready[w_wr_win] = 1'b1;
          w_wr_next           = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (m_awready) w_wr_next = WR_DATA;
      end
      WR_DATA: begin
        m_wvalid           = s_wvalid[r_wr_gnt];
        s_wready[r_wr_gnt] = m_wready;
        m_wdata            = s_wdata[r_wr_gnt*DATA_W +: DATA_W];
        m_wstrb            = s_wstrb[r_wr_gnt*SW +: SW];
        m_wlast            = s_wlast[r_wr_gnt];
        if (s_wvalid[r_wr_gnt] && m_wready && s_wlast[r_wr_gnt]) w_wr_next = WR_RESP;
      end
      WR_RESP: begin
        s_bvalid[r_wr_gnt] = m_bvalid;
        m_bready           = s_bready[r_wr_gnt];
        if (m_bvalid && s_bready[r_wr_gnt]) w_wr_next = WR_IDLE;
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  assign m_awvalid = (r_wr_state == WR_ADDR);
  assign m_awid    = ID_W'(r_wr_gnt);
  assign m_awaddr  = r_awaddr;
  assign m_awlen   = r_awlen;
  assign m_awsize  = r_awsize;
  assign m_awburst = 2'b01;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'b0000;
  assign m_awprot  = 3'b000;
  assign m_wid     = m_awid;
  assign s_bresp   = m_bresp;

  // -------------------------------------------------------------------- debug

  // Response IDs do not route anything. A mismatch is only flagged for observation.
  assign o_dbg_rsp_id_err = ((r_rd_state == RD_DATA) && m_rvalid && (m_rid != m_arid)) ||
                            ((r_wr_state == WR_RESP) && m_bvalid && (m_bid != m_awid));
  assign o_dbg_rd_state   = r_rd_state;
  assign o_dbg_wr_state   = r_wr_state;
  assign o_dbg_rd_ptr     = 3'(w_rd_ptr);
  assign o_dbg_wr_ptr     = 3'(w_wr_ptr);

endmodule
